// File: rtl/phase_meas_ctrl.sv
// Two-channel phase measurement sequencer.
// Synchronises comparator inputs A and B, times A-rise to B-rise and the A
// period in clk cycles, averages over 2^AVG_LOG2 periods and hands the
// result out over a valid/ready handshake. Timeout and abort supported.
module phase_meas_ctrl #(
    parameter int WIDTH    = 32,
    parameter int AVG_LOG2 = 3,
    parameter int TIMEOUT  = 100000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             sig_a,
    input  logic             sig_b,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_phase,
    output logic [WIDTH-1:0] res_period,
    output logic             timeout_err
);

    localparam int AW = WIDTH + AVG_LOG2;   // accumulator width
    localparam int NW = AVG_LOG2 + 1;       // sample counter width
    localparam int TW = $clog2(TIMEOUT);    // timeout counter width
    localparam logic [NW-1:0] N_LAST   = NW'((1 << AVG_LOG2) - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        WAIT_B = 3'd2,
        WAIT_A = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        sa_q, sb_q;
    logic [WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0]  phase_s_q, phase_s_d;
    logic [AW-1:0]     phase_acc_q, phase_acc_d, period_acc_q, period_acc_d;
    logic [AW-1:0]     phase_sum, period_sum, phase_avg, period_avg;
    logic [NW-1:0]     n_q, n_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [WIDTH-1:0]  res_phase_q, res_phase_d, res_period_q, res_period_d;
    logic              terr_q, terr_d;
    logic              a_rise, b_rise;

    // Two-flop synchroniser plus edge-detect flop for each comparator input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q <= '0;
            sb_q <= '0;
        end else begin
            sa_q <= {sa_q[1:0], sig_a};
            sb_q <= {sb_q[1:0], sig_b};
        end
    end

    // Same depth on both channels, so the pulses keep the pins' relative timing
    assign a_rise = sa_q[1] & ~sa_q[2];
    assign b_rise = sb_q[1] & ~sb_q[2];

    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);
    assign phase_sum  = phase_acc_q + AW'(phase_s_q);
    assign period_sum = period_acc_q + AW'(cnt_q);
    assign phase_avg  = phase_sum >> AVG_LOG2;
    assign period_avg = period_sum >> AVG_LOG2;

    // Next-state and datapath updates; abort overrides everything at the end
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_inc;
        phase_s_d    = phase_s_q;
        phase_acc_d  = phase_acc_q;
        period_acc_d = period_acc_q;
        n_d          = n_q;
        tmo_d        = tmo_q;
        res_phase_d  = res_phase_q;
        res_period_d = res_period_q;
        terr_d       = terr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = ARM;
                    phase_acc_d  = '0;
                    period_acc_d = '0;
                    n_d          = '0;
                    tmo_d        = '0;
                    terr_d       = 1'b0;
                    res_phase_d  = '0;
                    res_period_d = '0;
                end
            end
            ARM, WAIT_B, WAIT_A: begin
                tmo_d = tmo_q + TW'(1);
                if (tmo_q == TMO_LAST) begin
                    // No progress for too long: report an invalid, zeroed result
                    state_d      = DONE;
                    terr_d       = 1'b1;
                    res_phase_d  = '0;
                    res_period_d = '0;
                end else if (state_q == ARM) begin
                    if (a_rise) begin
                        cnt_d = WIDTH'(1);
                        tmo_d = '0;
                        if (b_rise) begin
                            phase_s_d = '0;
                            state_d   = WAIT_A;
                        end else begin
                            state_d   = WAIT_B;
                        end
                    end
                end else if (state_q == WAIT_B) begin
                    if (a_rise) begin
                        // B missed this period: restart timing from the new A edge
                        cnt_d = WIDTH'(1);
                        if (b_rise) begin
                            phase_s_d = '0;
                            state_d   = WAIT_A;
                        end
                    end else if (b_rise) begin
                        phase_s_d = cnt_q;
                        state_d   = WAIT_A;
                    end
                end else begin
                    if (a_rise) begin
                        phase_acc_d  = phase_sum;
                        period_acc_d = period_sum;
                        n_d          = n_q + NW'(1);
                        tmo_d        = '0;
                        if (n_q == N_LAST) begin
                            state_d      = DONE;
                            res_phase_d  = phase_avg[WIDTH-1:0];
                            res_period_d = period_avg[WIDTH-1:0];
                        end else begin
                            // This A edge also opens the next sample
                            cnt_d = WIDTH'(1);
                            if (b_rise) begin
                                phase_s_d = '0;
                                state_d   = WAIT_A;
                            end else begin
                                state_d   = WAIT_B;
                            end
                        end
                    end
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            terr_d  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            phase_s_q    <= '0;
            phase_acc_q  <= '0;
            period_acc_q <= '0;
            n_q          <= '0;
            tmo_q        <= '0;
            res_phase_q  <= '0;
            res_period_q <= '0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_s_q    <= phase_s_d;
            phase_acc_q  <= phase_acc_d;
            period_acc_q <= period_acc_d;
            n_q          <= n_d;
            tmo_q        <= tmo_d;
            res_phase_q  <= res_phase_d;
            res_period_q <= res_period_d;
            terr_q       <= terr_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign res_valid   = (state_q == DONE);
    assign res_phase   = res_phase_q;
    assign res_period  = res_period_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_phase_meas_ctrl.sv
// Self-checking bench for phase_meas_ctrl. Pin waveforms are built from
// lists of A/B rise times; expected results come from those edge lists.
module tb_phase_meas_ctrl;

    localparam int WIDTH = 32;
    localparam int AVG   = 2;
    localparam int TMO   = 1000;
    localparam int NS    = 1 << AVG;
    localparam int LAT   = 3;   // pin drive to visible FSM reaction, in cycles
    localparam int PW    = 4;   // pin pulse width, cycles

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0, abort = 1'b0, sig_a = 1'b0, sig_b = 1'b0;
    logic             res_ready = 1'b0;
    logic             busy, res_valid, timeout_err;
    logic [WIDTH-1:0] res_phase, res_period;

    int n_chk = 0;
    int n_fail = 0;
    int qa[$];
    int qb[$];
    int per[NS];
    int lag[NS];

    phase_meas_ctrl #(.WIDTH(WIDTH), .AVG_LOG2(AVG), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sig_a(sig_a), .sig_b(sig_b), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_phase(res_phase), .res_period(res_period),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic pin_hi(input bit sel_b, input int c);
        logic hi;
        hi = 1'b0;
        if (!sel_b) begin
            foreach (qa[i]) if (c >= qa[i] && c < qa[i] + PW) hi = 1'b1;
        end else begin
            foreach (qb[i]) if (c >= qb[i] && c < qb[i] + PW) hi = 1'b1;
        end
        return hi;
    endfunction

    task automatic idle_gap(input int n);
        start = 1'b0; abort = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Drive one measurement from qa/qb (cycle 0 = start pulse) and check it
    task automatic measure(input string tag, input int exp_cyc,
                           input logic [WIDTH-1:0] e_ph, input logic [WIDTH-1:0] e_pr,
                           input logic e_te, input int hold, input int xstart);
        int  seen;
        bit  stable;
        seen = -1;
        res_ready = (hold == 0);
        for (int c = 0; c < exp_cyc + 40 && seen < 0; c++) begin
            @(negedge clk);
            if (res_valid === 1'b1) seen = c;
            start = (c == 0) || (c == xstart);
            sig_a = pin_hi(1'b0, c);
            sig_b = pin_hi(1'b1, c);
        end
        start = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
        chk({tag, "_cycle"}, 64'(seen), 64'(exp_cyc));
        chk({tag, "_phase"}, 64'(res_phase), 64'(e_ph));
        chk({tag, "_period"}, 64'(res_period), 64'(e_pr));
        chk({tag, "_terr"}, 64'(timeout_err), 64'(e_te));
        if (hold > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (res_valid !== 1'b1 || res_phase !== e_ph ||
                    res_period !== e_pr || timeout_err !== e_te) stable = 1'b0;
                start = (h % 7 == 3);
            end
            chk({tag, "_hold_stable"}, 64'(stable), 64'd1);
            // handshake and start together: start must be ignored
            start = 1'b1; res_ready = 1'b1;
            @(negedge clk);
            start = 1'b0; res_ready = 1'b0;
            chk({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_phase_held"}, 64'(res_phase), 64'(e_ph));
        res_ready = 1'b0;
        idle_gap(8);
    endtask

    // Build edge lists from per/lag and run a regular measurement
    task automatic run_meas(input string tag, input int hold, input bit mid_start);
        longint sp, sl;
        qa.delete(); qb.delete();
        qa.push_back(6);
        sp = 0; sl = 0;
        for (int k = 0; k < NS; k++) begin
            qa.push_back(qa[k] + per[k]);
            qb.push_back(qa[k] + lag[k]);
            sp += per[k];
            sl += lag[k];
        end
        measure(tag, qa[NS] + LAT, WIDTH'(sl >> AVG), WIDTH'(sp >> AVG), 1'b0, hold,
                mid_start ? qa[2] + 1 : -1);
    endtask

    task automatic set_fixed(input int p, input int l);
        for (int k = 0; k < NS; k++) begin
            per[k] = p;
            lag[k] = l;
        end
    endtask

    initial begin
        bit got_v;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", 64'({busy, res_valid, timeout_err, res_phase, res_period}), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_idle", 64'({busy, res_valid, timeout_err, res_phase, res_period}), 64'd0);

        set_fixed(100, 25);
        run_meas("basic", 0, 1'b0);

        set_fixed(100, 0);
        lag[0] = 20; lag[1] = 22; lag[2] = 24; lag[3] = 26;
        run_meas("varlag", 0, 1'b0);

        set_fixed(64, 0);
        run_meas("coinc", 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NS; k++) begin
                per[k] = int'($urandom_range(120, 10));
                lag[k] = int'($urandom_range(per[k] - 5, 0));
            end
            run_meas($sformatf("rnd%0d", r), 0, (r % 2) == 1);
        end

        // B never rises: timeout counted from arming, WAIT_B restarts don't reset it
        qa.delete(); qb.delete();
        for (int k = 0; k < 12; k++) qa.push_back(6 + 100 * k);
        measure("tmo_b", 6 + LAT + TMO, '0, '0, 1'b1, 0, -1);

        // A never rises: timeout in ARM
        qa.delete(); qb.delete();
        measure("tmo_a", 1 + TMO, '0, '0, 1'b1, 0, -1);

        // consumer stalls 50 cycles; start pulses in DONE are ignored
        set_fixed(80, 30);
        run_meas("stall", 50, 1'b0);

        // abort during WAIT_B
        set_fixed(100, 40);
        qa.delete(); qb.delete();
        qa.push_back(6);
        for (int k = 0; k < NS; k++) begin
            qa.push_back(qa[k] + per[k]);
            qb.push_back(qa[k] + lag[k]);
        end
        got_v = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (c == 20) chk("abort_busy_before", 64'(busy), 64'd1);
            if (c == 21) chk("abort_outs", 64'({busy, res_valid, timeout_err}), 64'd0);
            if (res_valid === 1'b1) got_v = 1'b1;
            start = (c == 0);
            abort = (c == 20);
            sig_a = pin_hi(1'b0, c);
            sig_b = pin_hi(1'b1, c);
        end
        chk("abort_no_valid", 64'(got_v), 64'd0);
        idle_gap(8);
        set_fixed(90, 33);
        run_meas("post_abort", 0, 1'b0);

        // reset in WAIT_A
        set_fixed(100, 20);
        qa.delete(); qb.delete();
        qa.push_back(6);
        for (int k = 0; k < NS; k++) begin
            qa.push_back(qa[k] + per[k]);
            qb.push_back(qa[k] + lag[k]);
        end
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            start = (c == 0);
            sig_a = pin_hi(1'b0, c);
            sig_b = pin_hi(1'b1, c);
        end
        chk("rst_mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        start = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
        #1;
        chk("rst_mid_outs", 64'({busy, res_valid, timeout_err, res_phase, res_period}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_gap(8);
        chk("rst_mid_idle", 64'({busy, res_valid, timeout_err}), 64'd0);
        set_fixed(70, 11);
        run_meas("post_rst", 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
